cp_instr_packer: RTL and testbench

//  Inverse of the instruction field split: takes decoded RV32I fields plus a format tag and

---
 rtl/cp_instr_packer.sv | 133 +++++++++++++
 tb/tb_cp_instr_packer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/cp_instr_packer.sv
// Packs decoded RV32I fields into 32-bit instruction words, buffers them in a small FIFO and
// streams them out with a running word address for instruction-memory preload.
module cp_instr_packer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       restart_i,
  input  logic                       field_valid_i,
  output logic                       field_ready_o,
  input  logic [2:0]                 fmt_i,
  input  logic [6:0]                 opcode_i,
  input  logic [4:0]                 rd_addr_i,
  input  logic [4:0]                 rs1_addr_i,
  input  logic [4:0]                 rs2_addr_i,
  input  logic [2:0]                 func3_i,
  input  logic [6:0]                 func7_i,
  input  logic [31:0]                imm_i,
  output logic                       instr_valid_o,
  input  logic                       instr_ready_i,
  output logic [31:0]                instr_data_o,
  output logic [ADDR_W-1:0]          instr_addr_o,
  output logic                       err_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [2:0] {
    FmtR = 3'd0,
    FmtI = 3'd1,
    FmtS = 3'd2,
    FmtB = 3'd3,
    FmtU = 3'd4,
    FmtJ = 3'd5
  } fmt_e;

  logic [31:0]       r_mem [DEPTH];
  logic [PtrW-1:0]   r_wptr, r_rptr;
  logic [CntW-1:0]   r_count;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_data;
  logic              r_err;

  logic [31:0]       w_packed;
  logic              w_legal;
  logic              w_full;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic [CntW-1:0]   w_cnt_after_pop;
  logic [PtrW-1:0]   w_rptr_next;
  logic [31:0]       w_data_next;

  always_comb begin
    w_packed = '0;
    w_legal  = 1'b1;
    unique case (fmt_i)
      FmtR: w_packed = {func7_i, rs2_addr_i, rs1_addr_i, func3_i, rd_addr_i, opcode_i};
      FmtI: w_packed = {imm_i[11:0], rs1_addr_i, func3_i, rd_addr_i, opcode_i};
      FmtS: w_packed = {imm_i[11:5], rs2_addr_i, rs1_addr_i, func3_i, imm_i[4:0], opcode_i};
      FmtB: w_packed = {imm_i[12], imm_i[10:5], rs2_addr_i, rs1_addr_i, func3_i,
                        imm_i[4:1], imm_i[11], opcode_i};
      FmtU: w_packed = {imm_i[31:12], rd_addr_i, opcode_i};
      FmtJ: w_packed = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_addr_i, opcode_i};
      default: w_legal = 1'b0;
    endcase
  end

  // Ready depends only on registered occupancy, never on the consumer side.
  assign w_full   = (r_count == CntW'(DEPTH));
  assign w_accept = field_valid_i & ~w_full & ~restart_i;
  assign w_push   = w_accept & w_legal;
  assign w_pop    = (r_count != '0) & instr_ready_i & ~restart_i;

  assign w_cnt_after_pop = r_count - CntW'(w_pop);
  assign w_rptr_next     = r_rptr + PtrW'(w_pop);

  // Head register: holds the last word when the FIFO drains.
  always_comb begin
    w_data_next = r_data;
    if (!restart_i) begin
      if (w_cnt_after_pop != '0) begin
        w_data_next = r_mem[w_rptr_next];
      end else if (w_push) begin
        w_data_next = w_packed;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_packed;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_addr  <= BASE_ADDR;
      r_data  <= '0;
      r_err   <= 1'b0;
    end else if (restart_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_addr  <= BASE_ADDR;
      r_err   <= 1'b0;
    end else begin
      r_wptr  <= r_wptr + PtrW'(w_push);
      r_rptr  <= w_rptr_next;
      r_count <= w_cnt_after_pop + CntW'(w_push);
      r_data  <= w_data_next;
      r_err   <= w_accept & ~w_legal;
      if (w_pop) begin
        r_addr <= r_addr + ADDR_W'(4);
      end
    end
  end

  assign field_ready_o = ~w_full;
  assign instr_valid_o = (r_count != '0);
  assign instr_data_o  = r_data;
  assign instr_addr_o  = r_addr;
  assign err_o         = r_err;
  assign count_o       = r_count;

endmodule

// File: tb/tb_cp_instr_packer.sv
// Directed bench for cp_instr_packer: table of encodings plus back-pressure, illegal-format,
// restart and address-wrap sequences on a default and a narrow-address instance.
module tb_cp_instr_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        restart = 1'b0, fvalid = 1'b0, iready = 1'b0;
  logic [2:0]  fmt = '0;
  logic [6:0]  opcode = '0, func7 = '0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [2:0]  func3 = '0;
  logic [31:0] imm = '0;

  logic        fready, ivalid, err;
  logic [31:0] idata, iaddr;
  logic [2:0]  count;

  logic        n_restart = 1'b0, n_fvalid = 1'b0, n_iready = 1'b0;
  logic        n_fready, n_ivalid, n_err;
  logic [31:0] n_data;
  logic [3:0]  n_addr;
  logic [2:0]  n_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cp_instr_packer u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .restart_i(restart),
    .field_valid_i(fvalid), .field_ready_o(fready),
    .fmt_i(fmt), .opcode_i(opcode), .rd_addr_i(rd), .rs1_addr_i(rs1), .rs2_addr_i(rs2),
    .func3_i(func3), .func7_i(func7), .imm_i(imm),
    .instr_valid_o(ivalid), .instr_ready_i(iready), .instr_data_o(idata),
    .instr_addr_o(iaddr), .err_o(err), .count_o(count)
  );

  cp_instr_packer #(.DEPTH(4), .ADDR_W(4), .BASE_ADDR(4'hC)) u_dut_n (
    .clk_i(clk), .rst_n_i(rst_n), .restart_i(n_restart),
    .field_valid_i(n_fvalid), .field_ready_o(n_fready),
    .fmt_i(fmt), .opcode_i(opcode), .rd_addr_i(rd), .rs1_addr_i(rs1), .rs2_addr_i(rs2),
    .func3_i(func3), .func7_i(func7), .imm_i(imm),
    .instr_valid_o(n_ivalid), .instr_ready_i(n_iready), .instr_data_o(n_data),
    .instr_addr_o(n_addr), .err_o(n_err), .count_o(n_count)
  );

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input vec_t v);
    fmt = v.fmt; opcode = v.op; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2;
    func3 = v.f3; func7 = v.f7; imm = v.imm;
  endtask

  // lui x(k), (k << 12)
  function automatic vec_t lui_vec(input int k);
    vec_t v;
    v.fmt = 3'd4; v.op = 7'h37; v.rd = 5'(k); v.rs1 = 5'd0; v.rs2 = 5'd0;
    v.f3 = 3'd0; v.f7 = 7'd0; v.imm = 32'(k) << 12;
    v.exp = (32'(k) << 12) | (32'(k) << 7) | 32'h37;
    return v;
  endfunction

  logic [31:0] exp_addr;
  int          accepted;

  initial begin
    //          fmt   op     rd    rs1   rs2   f3    f7     imm            expected
    vecs[0] = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5,        32'h00500093};
    vecs[1] = '{3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0,        32'h002081B3};
    vecs[2] = '{3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'd8,        32'h0020A423};
    vecs[3] = '{3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'd8,        32'h00208463};
    vecs[4] = '{3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd16,       32'h010000EF};
    vecs[5] = '{3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000, 32'h123452B7};
    vecs[6] = '{3'd0, 7'h33, 5'd5, 5'd6, 5'd7, 3'd0, 7'h20, 32'd0,        32'h407302B3};
    vecs[7] = '{3'd1, 7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFF, 32'hFFF08093};

    #1 rst_n = 1'b0;
    #20;
    chk("rst_valid", 32'(ivalid), 32'd0);
    chk("rst_data", idata, 32'd0);
    chk("rst_addr", iaddr, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_n_addr", 32'(n_addr), 32'hC);
    @(negedge clk) rst_n = 1'b1;
    step();
    chk("rst_ready", 32'(fready), 32'd1);

    // Table: push one bundle, check head, pop it, check hold and address step.
    exp_addr = 32'd0;
    for (int i = 0; i < 8; i++) begin
      set_fields(vecs[i]);
      fvalid = 1'b1;
      step();
      fvalid = 1'b0;
      chk($sformatf("v%0d_count", i), 32'(count), 32'd1);
      chk($sformatf("v%0d_valid", i), 32'(ivalid), 32'd1);
      chk($sformatf("v%0d_data", i), idata, vecs[i].exp);
      chk($sformatf("v%0d_addr", i), iaddr, exp_addr);
      iready = 1'b1;
      step();
      iready = 1'b0;
      exp_addr += 32'd4;
      chk($sformatf("v%0d_empty", i), 32'(ivalid), 32'd0);
      chk($sformatf("v%0d_hold", i), idata, vecs[i].exp);
      chk($sformatf("v%0d_addr_inc", i), iaddr, exp_addr);
    end

    // Back-pressure: five offered, four fit.
    accepted = 0;
    for (int k = 1; k <= 5; k++) begin
      set_fields(lui_vec(k));
      fvalid = 1'b1;
      if (fready) accepted++;
      step();
    end
    fvalid = 1'b0;
    chk("bp_accepted", 32'(accepted), 32'd4);
    chk("bp_ready", 32'(fready), 32'd0);
    chk("bp_count", 32'(count), 32'd4);
    step();
    chk("bp_stable_data", idata, lui_vec(1).exp);
    chk("bp_stable_addr", iaddr, exp_addr);
    iready = 1'b1;
    #1;
    chk("bp_ready_full_pop", 32'(fready), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("bp_data%0d", k), idata, lui_vec(k).exp);
      chk($sformatf("bp_addr%0d", k), iaddr, exp_addr);
      step();
      exp_addr += 32'd4;
    end
    iready = 1'b0;
    chk("bp_drained", 32'(count), 32'd0);

    // Simultaneous push and pop keeps occupancy.
    set_fields(lui_vec(9));
    fvalid = 1'b1;
    step();
    set_fields(lui_vec(10));
    iready = 1'b1;
    step();
    fvalid = 1'b0;
    exp_addr += 32'd4;
    chk("pp_count", 32'(count), 32'd1);
    chk("pp_data", idata, lui_vec(10).exp);
    chk("pp_addr", iaddr, exp_addr);
    step();
    iready = 1'b0;
    exp_addr += 32'd4;
    chk("pp_drained", 32'(count), 32'd0);

    // Illegal format: consumed, one-cycle error, nothing queued.
    fmt = 3'd7;
    fvalid = 1'b1;
    step();
    fvalid = 1'b0;
    chk("ill_err", 32'(err), 32'd1);
    chk("ill_count", 32'(count), 32'd0);
    chk("ill_addr", iaddr, exp_addr);
    step();
    chk("ill_err_clear", 32'(err), 32'd0);

    // Restart beats a concurrent push/pop.
    set_fields(lui_vec(11));
    fvalid = 1'b1;
    step();
    restart = 1'b1;
    iready = 1'b1;
    step();
    restart = 1'b0;
    fvalid = 1'b0;
    iready = 1'b0;
    chk("rs_count", 32'(count), 32'd0);
    chk("rs_valid", 32'(ivalid), 32'd0);
    chk("rs_addr", iaddr, 32'd0);
    chk("rs_err", 32'(err), 32'd0);

    // Narrow address instance: 0xC then wrap to 0x0.
    set_fields(lui_vec(1));
    n_fvalid = 1'b1;
    step();
    set_fields(lui_vec(2));
    step();
    n_fvalid = 1'b0;
    chk("n_count", 32'(n_count), 32'd2);
    chk("n_addr0", 32'(n_addr), 32'hC);
    chk("n_data0", n_data, lui_vec(1).exp);
    n_iready = 1'b1;
    step();
    chk("n_addr1", 32'(n_addr), 32'h0);
    chk("n_data1", n_data, lui_vec(2).exp);
    step();
    n_iready = 1'b0;
    chk("n_addr2", 32'(n_addr), 32'h4);
    set_fields(lui_vec(3));
    n_fvalid = 1'b1;
    n_restart = 1'b1;
    step();
    n_fvalid = 1'b0;
    n_restart = 1'b0;
    chk("n_rs_count", 32'(n_count), 32'd0);
    chk("n_rs_addr", 32'(n_addr), 32'hC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
